latch_arbiter: RTL
==================

// Module: latch_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for one shared W-bit holding register (the latch resource).
//  N requesters post data; the block picks one winner, captures its data into q, and holds it
//  until the consumer accepts it (q_valid/q_ready).
//  Sits between requester logic and the shared storage element; one capture per transaction.
// PARAMETERS
//  N        4   number of requesters (>=1)
//  W        8   data width (>=1)
//  TIMEOUT  16  max HOLD cycles before forced drop (used only with LATCH_ARB_TIMEOUT_EN; >=1)
// PORTS
//  clk          in   1             system clock, rising edge; single clock domain
//  rst_n        in   1             asynchronous, active-low reset
//  req          in   N             level request per requester
//  wr_data      in   N*W           requester i data at [i*W +: W]
//  gnt          out  N             one-hot, one-cycle pulse: req i's data captured this edge
//  q            out  W             held data (shared register)
//  q_src        out  max(1,$clog2(N)) index of requester whose data is in q
//  q_valid      out  1             q holds unaccepted data
//  q_ready      in   1             consumer accepts q when q_valid && q_ready at a rising edge
//  busy         out  1             1 in HOLD state
//  timeout_err  out  1             sticky drop flag (port present only with LATCH_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, ptr=0, gnt=0, q=0, q_src=0, q_valid=0, busy=0,
//    timeout_err=0. Reset asserted mid-HOLD discards q; no handshake completes.
//  - Eligible requests: elig = req & ~gnt. Requester i is ignored in the cycle gnt[i]=1,
//    so a requester that drops req one edge after gnt is never double-granted.
//  - Pick: first set bit of elig scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//  - FSM states IDLE, HOLD:
//    IDLE: if |elig at edge -> q<=wr_data[w], q_src<=w, gnt<=onehot(w), q_valid<=1,
//      ptr<=(w==N-1)?0:w+1, state<=HOLD. Else all stay; gnt<=0.
//    HOLD: gnt<=0 after first cycle. On q_valid&&q_ready: if |elig -> capture next winner
//      same edge (back-to-back, stay HOLD, new gnt pulse); else q_valid<=0, state<=IDLE.
//      Without handshake: q, q_src, q_valid stable.
//  - Latency: req high at edge t (IDLE) -> gnt/q_valid high after edge t (1 cycle).
//    Sustained throughput: 1 transaction/cycle with q_ready tied 1.
//  - q retains last value after acceptance (not cleared). busy == (state==HOLD).
//  - N=1: ptr constant 0; q_src constant 0.
// CONFIGURATION
//  - Macro LATCH_ARB_TIMEOUT_EN.
//  - Defined: cycle counter cnt (width $clog2(TIMEOUT+1)) clears on capture, counts in HOLD.
//    On cnt==TIMEOUT-1 with no handshake: q_valid<=0, state<=IDLE, timeout_err<=1 (sticky
//    until reset). A handshake in the same cycle wins (no error).
//  - Undefined: no counter, no timeout_err port; HOLD waits indefinitely.
// STRUCTURE
//  - Package latch_arb_pkg: typedef enum logic {ST_IDLE, ST_HOLD} latch_arb_state_t;
//    function clog2_min1(n) for q_src/ptr width.
//  - Sub-module latch_arb_rr_pick: combinational (elig, ptr) -> (any, winner index, onehot).
//  - Top holds FSM, ptr, capture register, optional timeout counter.
// TESTING
//  1. Reset: rst_n=0 mid-HOLD with q=8'hA5 -> all outputs 0 immediately, before next clk.
//  2. Single req: N=4, req=4'b0100, wr_data[2]=8'h3C, q_ready=0 -> next edge gnt=4'b0100 one
//     cycle, q=8'h3C, q_src=2, q_valid=1 held 5 cycles; q_ready=1 -> q_valid=0, IDLE.
//  3. Round robin: req=4'b1111 held, q_ready=1 -> gnt sequence 0001,0010,0100,1000,0001,
//     one per cycle, q_src 0,1,2,3,0 (wrap check).
//  4. Pointer skip: ptr=3 after grant to 2, req=4'b0011 -> grant 0 then 1, not 1 first.
//  5. No double grant: only req[1] high, requester drops it one edge after gnt[1] -> exactly one
//     gnt pulse; q_valid high until q_ready.
//  6. Timeout (LATCH_ARB_TIMEOUT_EN, TIMEOUT=4): capture, q_ready=0 -> q_valid falls after 4
//     HOLD cycles, timeout_err=1 sticky; handshake on cycle 4 -> timeout_err stays 0.

Source files
------------

// File: rtl/latch_arb_pkg.sv
// rtl/latch_arb_pkg.sv - shared types and helpers for the latch arbiter
package latch_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } latch_arb_state_t;

  // Index width that stays at least one bit wide, so N=1 still has a q_src/ptr port
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/latch_arb_rr_pick.sv
// rtl/latch_arb_rr_pick.sv - combinational round-robin pick starting at ptr
module latch_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o,
  output logic [N-1:0]  onehot_o
);

  int cand;

  // Scan from the farthest position back toward ptr so the nearest eligible one is kept last
  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    cand     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % N;
      if (elig_i[cand]) begin
        any_o = 1'b1;
        idx_o = IW'(cand);
      end
    end
    if (any_o) begin
      onehot_o = N'(1) << idx_o;
    end
  end

endmodule

// File: rtl/latch_arbiter.sv
// rtl/latch_arbiter.sv - round-robin arbiter for one shared holding register; LATCH_ARB_TIMEOUT_EN adds a HOLD timeout
module latch_arbiter
  import latch_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              req,
  input  logic [N*W-1:0]            wr_data,
  output logic [N-1:0]              gnt,
  output logic [W-1:0]              q,
  output logic [clog2_min1(N)-1:0]  q_src,
  output logic                      q_valid,
  input  logic                      q_ready,
  output logic                      busy
`ifdef LATCH_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  localparam int IW = clog2_min1(N);

  if (N < 1 || W < 1 || TIMEOUT < 1) begin : g_param_err
    $error("latch_arbiter: N, W and TIMEOUT must all be >= 1");
  end

  latch_arb_state_t state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [W-1:0]     data_q, data_d;
  logic [IW-1:0]    src_q, src_d;
  logic             valid_q, valid_d;

  logic [N-1:0]     elig;
  logic             pick_any;
  logic [IW-1:0]    pick_idx;
  logic [N-1:0]     pick_onehot;
  logic             hs;
  logic             capture;
  logic             drop;
  logic             tmo_fire;

  // A requester granted this cycle is masked so a one-cycle-late req drop never double-grants
  assign elig = req & ~gnt_q;
  assign hs   = valid_q & q_ready;

  latch_arb_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .elig_i   (elig),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

`ifdef LATCH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  // A handshake in the last allowed cycle takes priority over the forced drop
  assign tmo_fire = (state_q == ST_HOLD) && !hs && (cnt_q == CNT_LAST);

  // Cycle counter restarts on every capture and advances while holding
  always_comb begin
    cnt_d  = cnt_q;
    terr_d = terr_q | tmo_fire;
    if (capture) begin
      cnt_d = '0;
    end else if (state_q == ST_HOLD) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Timeout counter and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign tmo_fire = 1'b0;
`endif

  // Capture from IDLE on any request, or back-to-back on a handshake; drop when nothing follows
  always_comb begin
    capture = 1'b0;
    drop    = 1'b0;
    if (state_q == ST_IDLE) begin
      capture = pick_any;
    end else if (hs) begin
      capture = pick_any;
      drop    = !pick_any;
    end else begin
      drop    = tmo_fire;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = ST_HOLD;
    end else if (drop) begin
      state_d = ST_IDLE;
    end
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_HOLD);
  end

  // Datapath next values: q retains its last value after acceptance
  always_comb begin
    ptr_d   = ptr_q;
    gnt_d   = '0;
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    if (capture) begin
      gnt_d   = pick_onehot;
      data_d  = wr_data[int'(pick_idx)*W +: W];
      src_d   = pick_idx;
      valid_d = 1'b1;
      ptr_d   = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
    end else if (drop) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_src   = src_q;
  assign q_valid = valid_q;

endmodule
